// File: rtl/stack_unit.sv
// LIFO stack for data bytes and return addresses, with registered pop data and
// sticky overflow/underflow flags. Storage is never reset; Count alone gates access.
module stack_unit #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       Reset,
    input  logic                       StackWrite,
    input  logic                       StackRead,
    input  logic [WIDTH-1:0]           Datain,
    input  logic                       ErrClear,
    output logic [WIDTH-1:0]           Dataout,
    output logic                       DataValid,
    output logic [$clog2(DEPTH):0]     Count,
    output logic                       Full,
    output logic                       Empty,
    output logic                       Overflow,
    output logic                       Underflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [WIDTH-1:0] mem_wdata;

    logic [AW-1:0]    wr_addr;
    logic [AW-1:0]    top_addr;
    logic             full;
    logic             empty;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign wr_addr  = count_q[AW-1:0];
    assign top_addr = AW'(count_q - CW'(1));

    always_comb begin
        count_d   = count_q;
        dout_d    = dout_q;
        valid_d   = 1'b0;
        ovf_d     = ErrClear ? 1'b0 : ovf_q;
        unf_d     = ErrClear ? 1'b0 : unf_q;
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = Datain;

        unique case ({StackWrite, StackRead})
            2'b10: begin
                if (full) begin
                    ovf_d = 1'b1;
                end else begin
                    mem_we  = 1'b1;
                    count_d = count_q + CW'(1);
                end
            end
            2'b01: begin
                if (empty) begin
                    unf_d = 1'b1;
                end else begin
                    dout_d  = mem_q[top_addr];
                    valid_d = 1'b1;
                    count_d = count_q - CW'(1);
                end
            end
            2'b11: begin
                valid_d = 1'b1;
                if (empty) begin
                    // Nothing to swap with: forward the pushed value straight out.
                    dout_d = Datain;
                end else begin
                    dout_d    = mem_q[top_addr];
                    mem_we    = 1'b1;
                    mem_waddr = top_addr;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            count_q <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we && !Reset) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign Dataout   = dout_q;
    assign DataValid = valid_q;
    assign Count     = count_q;
    assign Full      = full;
    assign Empty     = empty;
    assign Overflow  = ovf_q;
    assign Underflow = unf_q;

endmodule

// File: tb/tb_stack_unit.sv
// Directed bench for stack_unit (DEPTH=16, WIDTH=8) with hand-computed expectations.
module tb_stack_unit;

    logic       clk;
    logic       Reset;
    logic       StackWrite;
    logic       StackRead;
    logic [7:0] Datain;
    logic       ErrClear;
    logic [7:0] Dataout;
    logic       DataValid;
    logic [4:0] Count;
    logic       Full;
    logic       Empty;
    logic       Overflow;
    logic       Underflow;

    int checks = 0;
    int errors = 0;

    stack_unit #(
        .DEPTH(16),
        .WIDTH(8)
    ) dut (
        .clk       (clk),
        .Reset     (Reset),
        .StackWrite(StackWrite),
        .StackRead (StackRead),
        .Datain    (Datain),
        .ErrClear  (ErrClear),
        .Dataout   (Dataout),
        .DataValid (DataValid),
        .Count     (Count),
        .Full      (Full),
        .Empty     (Empty),
        .Overflow  (Overflow),
        .Underflow (Underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Apply one cycle of inputs, then sample 1 time unit after the edge.
    task automatic cyc(input logic rst, input logic w, input logic r, input logic [7:0] d,
                       input logic clr);
        Reset      = rst;
        StackWrite = w;
        StackRead  = r;
        Datain     = d;
        ErrClear   = clr;
        @(posedge clk);
        #1;
        Reset      = 1'b0;
        StackWrite = 1'b0;
        StackRead  = 1'b0;
        ErrClear   = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        cyc(1'b0, 1'b1, 1'b0, d, 1'b0);
    endtask

    task automatic pop();
        cyc(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    endtask

    initial begin
        Reset = 1'b1; StackWrite = 1'b0; StackRead = 1'b0; Datain = '0; ErrClear = 1'b0;
        @(negedge clk);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        check("rst_count", Count, 0);
        check("rst_empty", Empty, 1);
        check("rst_full", Full, 0);
        check("rst_dout", Dataout, 0);
        check("rst_valid", DataValid, 0);
        check("rst_ovf", Overflow, 0);
        check("rst_unf", Underflow, 0);

        // LIFO order
        push(8'h11); push(8'h22); push(8'h33);
        check("lifo_count3", Count, 3);
        check("lifo_valid_on_push", DataValid, 0);
        pop();
        check("lifo_pop1", Dataout, 8'h33);
        check("lifo_pop1_v", DataValid, 1);
        check("lifo_pop1_cnt", Count, 2);
        pop();
        check("lifo_pop2", Dataout, 8'h22);
        check("lifo_pop2_v", DataValid, 1);
        pop();
        check("lifo_pop3", Dataout, 8'h11);
        check("lifo_pop3_v", DataValid, 1);
        check("lifo_cnt0", Count, 0);
        check("lifo_empty", Empty, 1);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        check("idle_valid", DataValid, 0);
        check("idle_dout", Dataout, 8'h11);

        // Underflow and clear
        pop();
        check("unf_set", Underflow, 1);
        check("unf_valid", DataValid, 0);
        check("unf_dout", Dataout, 8'h11);
        check("unf_cnt", Count, 0);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check("unf_clear", Underflow, 0);

        // Push+pop on empty: pass-through
        cyc(1'b0, 1'b1, 1'b1, 8'h5C, 1'b0);
        check("pt_dout", Dataout, 8'h5C);
        check("pt_valid", DataValid, 1);
        check("pt_cnt", Count, 0);
        check("pt_unf", Underflow, 0);

        // Push+pop on non-empty: swap top
        push(8'h05); push(8'h07);
        cyc(1'b0, 1'b1, 1'b1, 8'h09, 1'b0);
        check("swap_dout", Dataout, 8'h07);
        check("swap_valid", DataValid, 1);
        check("swap_cnt", Count, 2);
        pop();
        check("swap_pop_top", Dataout, 8'h09);
        check("swap_pop_cnt", Count, 1);
        pop();
        check("swap_pop_bottom", Dataout, 8'h05);
        check("swap_empty", Empty, 1);

        // Fill to full, then overflow
        for (int i = 0; i < 16; i++) push(8'(i));
        check("full_cnt", Count, 16);
        check("full_flag", Full, 1);
        check("full_not_empty", Empty, 0);
        check("full_no_ovf", Overflow, 0);
        push(8'hAA);
        check("ovf_set", Overflow, 1);
        check("ovf_cnt", Count, 16);
        pop();
        check("ovf_pop", Dataout, 8'h0F);
        check("ovf_pop_cnt", Count, 15);
        check("ovf_not_full", Full, 0);
        push(8'h77);
        cyc(1'b0, 1'b1, 1'b1, 8'hBB, 1'b0);
        check("full_swap_dout", Dataout, 8'h77);
        check("full_swap_cnt", Count, 16);
        // Set beats clear in the same cycle
        cyc(1'b0, 1'b1, 1'b0, 8'hCC, 1'b1);
        check("ovf_set_wins", Overflow, 1);
        pop();
        check("full_swap_stored", Dataout, 8'hBB);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check("ovf_clear", Overflow, 0);

        // Reset mid-sequence overrides a push
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        check("mid_cnt4", Count, 4);
        pop();
        check("mid_pop", Dataout, 8'h04);
        cyc(1'b1, 1'b1, 1'b0, 8'hEE, 1'b0);
        check("mid_rst_cnt", Count, 0);
        check("mid_rst_dout", Dataout, 0);
        check("mid_rst_valid", DataValid, 0);
        check("mid_rst_ovf", Overflow, 0);
        check("mid_rst_unf", Underflow, 0);
        pop();
        check("mid_pop_unf", Underflow, 1);
        check("mid_pop_valid", DataValid, 0);
        check("mid_pop_cnt", Count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stack_unit.md
STACK_UNIT -- requirements
Module: stack_unit

Interface
REQ-001 Parameter DEPTH, default 16, number of stack entries; SHALL be a power of two, 2 to 256.
REQ-002 Parameter WIDTH, default 8, bits per entry (data bytes and PC return addresses).
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 StackWrite  input  1  push request from control logic, one push per cycle high.
REQ-006 StackRead  input  1  pop request from control logic, one pop per cycle high.
REQ-007 Datain  input  WIDTH  push data (ALU result or PC_D2 return address).
REQ-008 ErrClear  input  1  clears sticky Overflow/Underflow.
REQ-009 Dataout  output  WIDTH  registered pop data.
REQ-010 DataValid  output  1  high for exactly one cycle when Dataout carries newly popped data.
REQ-011 Count  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-012 Full  output  1  combinational, (Count == DEPTH).
REQ-013 Empty  output  1  combinational, (Count == 0).
REQ-014 Overflow  output  1  sticky: push attempted while full.
REQ-015 Underflow  output  1  sticky: pop attempted while empty.

Function
REQ-016 Storage SHALL be DEPTH x WIDTH registers; write address = Count[log2(DEPTH)-1:0], top-of-stack = Count-1.
REQ-017 Push only (StackWrite=1, StackRead=0, not Full): mem[Count] <= Datain, Count <= Count+1; Dataout/DataValid unaffected except DataValid returns 0.
REQ-018 Pop only (StackRead=1, StackWrite=0, not Empty): Dataout <= mem[Count-1], Count <= Count-1, DataValid <= 1 next cycle (latency 1 clock).
REQ-019 Push while Full (push only): no write, Count unchanged, Overflow <= 1.
REQ-020 Pop while Empty (pop only): Count unchanged, Dataout holds previous value, DataValid <= 0, Underflow <= 1.
REQ-021 Simultaneous push and pop, not Empty: Dataout <= mem[Count-1], mem[Count-1] <= Datain, Count unchanged, DataValid <= 1; no Overflow even if Full.
REQ-022 Simultaneous push and pop while Empty: Dataout <= Datain (pass-through), Count stays 0, DataValid <= 1, no Underflow, no memory write.
REQ-023 Neither request: DataValid <= 0; all other state holds.
REQ-024 Count SHALL never exceed DEPTH nor wrap below 0; no pointer wrap-around.
REQ-025 ErrClear=1 clears Overflow and Underflow; if a new error event occurs the same cycle, the set wins.
REQ-026 Full/Empty SHALL reflect registered Count in the same cycle (no lookahead).

Reset
REQ-027 Reset=1 at a clock edge: Count <= 0, Dataout <= 0, DataValid <= 0, Overflow <= 0, Underflow <= 0; Empty=1, Full=0 thereafter.
REQ-028 Reset SHALL override any coincident StackWrite/StackRead/ErrClear; a push/pop in the reset cycle has no effect.
REQ-029 Memory array contents are not reset; they SHALL be unreachable until rewritten, because Count=0.
REQ-030 Reset asserted mid-sequence (stack partly full) SHALL discard all entries; the first pop after reset SHALL set Underflow.

Verification
REQ-031 Reset, push 0x11, 0x22, 0x33, pop x3 -> Dataout 0x33, 0x22, 0x11 on consecutive cycles, each with DataValid=1; Count 3->0; Empty=1.
REQ-032 DEPTH=16: push 0x00..0x0F, then push 0xAA -> Full=1, Count=16, Overflow=1; pop -> Dataout=0x0F (0xAA not stored).
REQ-033 Empty stack, pop -> Underflow=1, DataValid=0, Dataout unchanged; ErrClear=1 one cycle -> Underflow=0.
REQ-034 Stack holds {0x05, 0x07}, push 0x09 with pop in the same cycle -> Dataout=0x07, DataValid=1, Count=2; next pop -> 0x09.
REQ-035 Empty stack, push 0x5C with pop in the same cycle -> Dataout=0x5C, DataValid=1, Count=0, Underflow=0.
REQ-036 Push 4 entries, assert Reset with StackWrite=1 in the same cycle -> Count=0, flags 0, Dataout=0; next pop -> Underflow=1.
